// File: rtl/hyper_seq_ctrl.sv
// hyper_seq_ctrl
// Sequencer for the f1/f2 capture path. A start request opens the capture
// window and one FRAME_LEN-word frame is counted from the pi_flag/pi_data
// stream. Words 0 and 1 are recorded, validated and ordered, then handed
// to a single consumer over a valid/ready handshake. Timeouts and invalid
// pairs cause bounded automatic retries. Sticky error flags latch when the
// retries run out.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         run request (IDLE/ERR only) and unconditional stop
//   pi_flag, pi_data     input word strobe and 32-bit word
//   cap_en               capture window enable to the datapath
//   busy                 high in every state except IDLE and ERR
//   out_valid, out_ready result handshake
//   out_f1, out_f2       smaller / larger parameter
//   err_timeout          final attempt timed out (sticky)
//   err_invalid          final attempt produced an invalid pair (sticky)
//   retry_cnt            retries used in the current or last run
module hyper_seq_ctrl #(
  parameter int FRAME_LEN = 1024,
  parameter int TIMEOUT   = 50_000_000,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        pi_flag,
  input  logic [31:0] pi_data,
  output logic        cap_en,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_f1,
  output logic [31:0] out_f2,
  output logic        err_timeout,
  output logic        err_invalid,
  output logic [3:0]  retry_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN) + 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] TIMER_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CHECK,
    RESTART,
    PRESENT,
    ERR
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  word_cnt;
  logic [TMR_W-1:0]  timer;
  logic [31:0]       raw1;
  logic [31:0]       raw2;
  logic              frame_done;
  logic              pair_invalid;
  logic              retry_left;

  // The final word wins over a timeout that expires in the same cycle.
  assign frame_done   = (state == CAPTURE) && pi_flag && (word_cnt == LAST_WORD);
  assign pair_invalid = (raw1 == 32'd0) || (raw2 == 32'd0) || (raw1 == raw2);
  assign retry_left   = (retry_cnt < RETRY_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_cnt    <= '0;
      timer       <= '0;
      raw1        <= '0;
      raw2        <= '0;
      cap_en      <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_f1      <= '0;
      out_f2      <= '0;
      err_timeout <= 1'b0;
      err_invalid <= 1'b0;
      retry_cnt   <= '0;
    end else if (abort) begin
      // out_f1/out_f2 deliberately keep their last values.
      state       <= IDLE;
      word_cnt    <= '0;
      timer       <= '0;
      cap_en      <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      err_timeout <= 1'b0;
      err_invalid <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state       <= CAPTURE;
            word_cnt    <= '0;
            timer       <= '0;
            cap_en      <= 1'b1;
            busy        <= 1'b1;
            err_timeout <= 1'b0;
            err_invalid <= 1'b0;
            retry_cnt   <= '0;
          end
        end

        CAPTURE: begin
          timer <= timer + TMR_W'(1);
          if (pi_flag) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (word_cnt == '0)
              raw1 <= pi_data;
            if (word_cnt == CNT_W'(1))
              raw2 <= pi_data;
          end
          if (frame_done) begin
            state <= CHECK;
          end else if (timer == TIMER_LAST) begin
            cap_en <= 1'b0;
            if (retry_left) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= RESTART;
            end else begin
              state       <= ERR;
              busy        <= 1'b0;
              err_timeout <= 1'b1;
            end
          end
        end

        // cap_en stays high here so a retry shows exactly one low cycle.
        CHECK: begin
          cap_en <= 1'b0;
          if (pair_invalid) begin
            if (retry_left) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= RESTART;
            end else begin
              state       <= ERR;
              busy        <= 1'b0;
              err_invalid <= 1'b1;
            end
          end else begin
            out_f1    <= (raw1 < raw2) ? raw1 : raw2;
            out_f2    <= (raw1 < raw2) ? raw2 : raw1;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end

        // One low cycle of cap_en lets the datapath clear its frame counter.
        RESTART: begin
          word_cnt <= '0;
          timer    <= '0;
          cap_en   <= 1'b1;
          state    <= CAPTURE;
        end

        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cap_en    <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_seq_ctrl.sv
// tb_hyper_seq_ctrl
// Directed bench for hyper_seq_ctrl with FRAME_LEN=8, TIMEOUT=40,
// MAX_RETRY=2. Inputs change and outputs are sampled on the falling edge;
// the DUT acts on the rising edge in between.
module tb_hyper_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        pi_flag;
  logic [31:0] pi_data;
  logic        cap_en;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f1;
  logic [31:0] out_f2;
  logic        err_timeout;
  logic        err_invalid;
  logic [3:0]  retry_cnt;

  int checks = 0;
  int errors = 0;

  hyper_seq_ctrl #(
    .FRAME_LEN (8),
    .TIMEOUT   (40),
    .MAX_RETRY (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .pi_flag     (pi_flag),
    .pi_data     (pi_data),
    .cap_en      (cap_en),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_f1      (out_f1),
    .out_f2      (out_f2),
    .err_timeout (err_timeout),
    .err_invalid (err_invalid),
    .retry_cnt   (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then wait for the next falling edge.
  task automatic applyStimulus(input logic s, input logic a, input logic f,
                               input logic [31:0] d, input logic r);
    start     = s;
    abort     = a;
    pi_flag   = f;
    pi_data   = d;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic r);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, r);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pi_flag   = 1'b0;
    pi_data   = 32'h0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    checkOutput("rst_cap_en",    {31'b0, cap_en},      32'h0);
    checkOutput("rst_busy",      {31'b0, busy},        32'h0);
    checkOutput("rst_out_valid", {31'b0, out_valid},   32'h0);
    checkOutput("rst_f1",        out_f1,               32'h0);
    checkOutput("rst_f2",        out_f2,               32'h0);
    checkOutput("rst_err_to",    {31'b0, err_timeout}, 32'h0);
    checkOutput("rst_retry",     {28'b0, retry_cnt},   32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal frame; word 0 lands on the first CAPTURE cycle.
    $display("[TB] normal frame");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("start_cap_en", {31'b0, cap_en}, 32'h1);
    checkOutput("start_busy",   {31'b0, busy},   32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h120, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
    checkOutput("n_check_valid", {31'b0, out_valid}, 32'h0);
    idleCycles(1, 1'b0);
    checkOutput("n_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("n_f1",    out_f1,             32'h120);
    checkOutput("n_f2",    out_f2,             32'h300);

    // Back-pressure with stray flags that must be ignored.
    $display("[TB] back-pressure");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
      checkOutput("bp_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("bp_f1",    out_f1,             32'h120);
      checkOutput("bp_f2",    out_f2,             32'h300);
    end
    idleCycles(1, 1'b1);
    checkOutput("bp_xfer_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("bp_xfer_busy",  {31'b0, busy},      32'h0);
    idleCycles(1, 1'b1);
    checkOutput("bp_single", {31'b0, out_valid}, 32'h0);

    // Invalid pair, then a valid frame after a single retry.
    $display("[TB] invalid then valid");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
    checkOutput("inv_check_cap", {31'b0, cap_en}, 32'h1);
    idleCycles(1, 1'b0);
    checkOutput("inv_restart_cap", {31'b0, cap_en},    32'h0);
    checkOutput("inv_retry",       {28'b0, retry_cnt}, 32'h1);
    checkOutput("inv_busy",        {31'b0, busy},      32'h1);
    idleCycles(1, 1'b0);
    checkOutput("inv_recap", {31'b0, cap_en}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h3, 1'b0);
    idleCycles(1, 1'b0);
    checkOutput("inv_valid",   {31'b0, out_valid}, 32'h1);
    checkOutput("inv_f1",      out_f1,             32'h10);
    checkOutput("inv_f2",      out_f2,             32'h20);
    checkOutput("inv_retry_2", {28'b0, retry_cnt}, 32'h1);
    idleCycles(1, 1'b1);
    checkOutput("inv_done", {31'b0, busy}, 32'h0);

    // Timeout exhaustion: three 40-cycle attempts, then ERR.
    $display("[TB] timeout exhaustion");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idleCycles(39, 1'b0);
    checkOutput("to_a1_open", {31'b0, cap_en}, 32'h1);
    idleCycles(1, 1'b0);
    checkOutput("to_r1_cap",   {31'b0, cap_en},    32'h0);
    checkOutput("to_r1_retry", {28'b0, retry_cnt}, 32'h1);
    idleCycles(1, 1'b0);
    checkOutput("to_a2_cap", {31'b0, cap_en}, 32'h1);
    idleCycles(39, 1'b0);
    checkOutput("to_a2_open", {31'b0, cap_en}, 32'h1);
    idleCycles(1, 1'b0);
    checkOutput("to_r2_cap",   {31'b0, cap_en},    32'h0);
    checkOutput("to_r2_retry", {28'b0, retry_cnt}, 32'h2);
    idleCycles(1, 1'b0);
    idleCycles(39, 1'b0);
    checkOutput("to_a3_open", {31'b0, cap_en},      32'h1);
    checkOutput("to_a3_err",  {31'b0, err_timeout}, 32'h0);
    idleCycles(1, 1'b0);
    checkOutput("to_err_flag",  {31'b0, err_timeout}, 32'h1);
    checkOutput("to_err_inv",   {31'b0, err_invalid}, 32'h0);
    checkOutput("to_err_retry", {28'b0, retry_cnt},   32'h2);
    checkOutput("to_err_busy",  {31'b0, busy},        32'h0);
    checkOutput("to_err_cap",   {31'b0, cap_en},      32'h0);
    idleCycles(3, 1'b0);
    checkOutput("to_err_hold", {31'b0, err_timeout}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("to_restart_clr",   {31'b0, err_timeout}, 32'h0);
    checkOutput("to_restart_retry", {28'b0, retry_cnt},   32'h0);
    checkOutput("to_restart_busy",  {31'b0, busy},        32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("to_abort_busy", {31'b0, busy}, 32'h0);

    // Final word on the 40th CAPTURE cycle collides with the timeout.
    $display("[TB] collision");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h50, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h9, 1'b0);
    idleCycles(32, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h9, 1'b0);
    checkOutput("col_check_cap", {31'b0, cap_en}, 32'h1);
    idleCycles(1, 1'b0);
    checkOutput("col_valid", {31'b0, out_valid},   32'h1);
    checkOutput("col_f1",    out_f1,               32'h40);
    checkOutput("col_f2",    out_f2,               32'h50);
    checkOutput("col_retry", {28'b0, retry_cnt},   32'h0);
    checkOutput("col_err",   {31'b0, err_timeout}, 32'h0);
    idleCycles(1, 1'b1);

    // Abort part-way through a frame, then a clean frame from word 0.
    $display("[TB] abort and reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hBBB, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hCCC, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDDD, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("ab_cap",   {31'b0, cap_en}, 32'h0);
    checkOutput("ab_busy",  {31'b0, busy},   32'h0);
    checkOutput("ab_f1_kept", out_f1,        32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h222, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h111, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h7, 1'b0);
    idleCycles(1, 1'b0);
    checkOutput("ab_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("ab_f1",    out_f1,             32'h111);
    checkOutput("ab_f2",    out_f2,             32'h222);

    // Asynchronous reset in the middle of the low clock phase.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("ar_f1",    out_f1,             32'h0);
    checkOutput("ar_busy",  {31'b0, busy},      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2, 1'b0);
    checkOutput("ar_idle", {31'b0, cap_en}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
